bnn_seq_classifier: RTL and testbench

BNN_SEQ_CLASSIFIER -- requirements
Module: bnn_seq_classifier

---
 rtl/bnn_pkg.sv | 21 ++
 rtl/bnn_argmax.sv | 28 ++
 rtl/bnn_seq_classifier.sv | 132 +++++++++++++
 tb/tb_bnn_seq_classifier.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// bnn_pkg: FSM state encoding and width helpers shared by the BNN classifier
package bnn_pkg;

    typedef enum logic [1:0] {IDLE, L1, L2, DONE} state_t;

    // Signed hidden accumulator width: magnitude of the worst-case sum plus a sign bit
    function automatic int acc_w(input int f, input int b);
        return $clog2(f * (2 ** b - 1) + 1) + 1;
    endfunction

    // Class popcount width: must hold HIDDEN_CNT itself
    function automatic int cnt_w(input int h);
        return $clog2(h + 1);
    endfunction

    // Step index width: covers FEAT_CNT-1 in L1 and HIDDEN_CNT in L2 (the argmax step)
    function automatic int idx_w(input int f, input int h);
        return $clog2((f > h ? f : h) + 1);
    endfunction

endpackage

// File: rtl/bnn_argmax.sv
// bnn_argmax: combinational argmax over packed class counts, lowest index wins ties
module bnn_argmax
    import bnn_pkg::*;
#(
    parameter int CLASS_CNT = 7,
    parameter int CNT_W     = 6
) (
    input  logic [CLASS_CNT*CNT_W-1:0]     i_cnt,
    output logic [$clog2(CLASS_CNT)-1:0]   o_idx
);

    localparam int PW = $clog2(CLASS_CNT);

    logic [CNT_W-1:0] w_best;

    // Strict greater-than keeps the earliest class on equal counts
    always_comb begin
        w_best = i_cnt[CNT_W-1:0];
        o_idx  = '0;
        for (int c = 1; c < CLASS_CNT; c++) begin
            if (i_cnt[c*CNT_W +: CNT_W] > w_best) begin
                w_best = i_cnt[c*CNT_W +: CNT_W];
                o_idx  = PW'(c);
            end
        end
    end

endmodule

// File: rtl/bnn_seq_classifier.sv
// bnn_seq_classifier: sequential two-layer binary neural net classifier.
// Optional score output enabled by defining BNN_SCORE_OUT_EN.
module bnn_seq_classifier
    import bnn_pkg::*;
#(
    parameter int FEAT_CNT   = 11,
    parameter int FEAT_BITS  = 4,
    parameter int HIDDEN_CNT = 40,
    parameter int CLASS_CNT  = 7,
    parameter logic [HIDDEN_CNT*FEAT_CNT-1:0]  W1 = '0,
    parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] W2 = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [FEAT_BITS*FEAT_CNT-1:0]   features,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [$clog2(CLASS_CNT)-1:0]    prediction,
    output logic                            out_valid,
`ifdef BNN_SCORE_OUT_EN
    output logic [cnt_w(HIDDEN_CNT)-1:0]    score,
`endif
    input  logic                            out_ready
);

    localparam int AW = acc_w(FEAT_CNT, FEAT_BITS);
    localparam int CW = cnt_w(HIDDEN_CNT);
    localparam int IW = idx_w(FEAT_CNT, HIDDEN_CNT);
    localparam int PW = $clog2(CLASS_CNT);

    state_t                         r_state, w_next;
    logic [FEAT_BITS*FEAT_CNT-1:0]  r_feat;
    logic signed [AW-1:0]           r_acc [HIDDEN_CNT];
    logic [CW-1:0]                  r_cnt [CLASS_CNT];
    logic [IW-1:0]                  r_idx;
    logic [PW-1:0]                  r_pred;
    logic [HIDDEN_CNT-1:0]          w_w1b, w_hid;
    logic [CLASS_CNT-1:0]           w_w2b;
    logic [CLASS_CNT*CW-1:0]        w_cnt_flat;
    logic [PW-1:0]                  w_arg;
    logic signed [AW-1:0]           w_x;
    logic                           w_hbit, w_last_f, w_last_h;

    // The captured sample is shifted down each L1 step, so the current feature is always at the LSB
    assign w_x        = AW'(r_feat[FEAT_BITS-1:0]);
    assign w_last_f   = r_idx == IW'(FEAT_CNT - 1);
    assign w_last_h   = r_idx == IW'(HIDDEN_CNT);
    assign w_hbit     = 1'(w_hid >> r_idx);
    assign in_ready   = r_state == IDLE;
    assign out_valid  = r_state == DONE;
    assign prediction = r_pred;

    for (genvar h = 0; h < HIDDEN_CNT; h++) begin : g_hid
        assign w_w1b[h] = 1'(W1[h*FEAT_CNT +: FEAT_CNT] >> r_idx);
        assign w_hid[h] = ~r_acc[h][AW-1];
    end

    for (genvar c = 0; c < CLASS_CNT; c++) begin : g_cls
        assign w_w2b[c]                 = 1'(W2[c*HIDDEN_CNT +: HIDDEN_CNT] >> r_idx);
        assign w_cnt_flat[c*CW +: CW]   = r_cnt[c];
    end

    bnn_argmax #(
        .CLASS_CNT (CLASS_CNT),
        .CNT_W     (CW)
    ) u_argmax (
        .i_cnt (w_cnt_flat),
        .o_idx (w_arg)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next state: L2 runs one extra step (index HIDDEN_CNT) to register the argmax
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = in_valid  ? L1   : IDLE;
            L1:      w_next = w_last_f  ? L2   : L1;
            L2:      w_next = w_last_h  ? DONE : L2;
            DONE:    w_next = out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: sample capture, layer-1 accumulation, layer-2 XNOR popcount, result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_feat <= '0;
            r_idx  <= '0;
            r_pred <= '0;
            for (int i = 0; i < HIDDEN_CNT; i++) r_acc[i] <= '0;
            for (int i = 0; i < CLASS_CNT; i++)  r_cnt[i] <= '0;
        end else if (r_state == IDLE) begin
            if (in_valid) begin
                r_feat <= features;
                r_idx  <= '0;
                for (int i = 0; i < HIDDEN_CNT; i++) r_acc[i] <= '0;
                for (int i = 0; i < CLASS_CNT; i++)  r_cnt[i] <= '0;
            end
        end else if (r_state == L1) begin
            r_feat <= r_feat >> FEAT_BITS;
            r_idx  <= w_last_f ? '0 : r_idx + 1'b1;
            for (int i = 0; i < HIDDEN_CNT; i++)
                r_acc[i] <= w_w1b[i] ? r_acc[i] + w_x : r_acc[i] - w_x;
        end else if (r_state == L2) begin
            if (w_last_h) begin
                r_pred <= w_arg;
            end else begin
                r_idx <= r_idx + 1'b1;
                for (int i = 0; i < CLASS_CNT; i++)
                    if (w_w2b[i] == w_hbit) r_cnt[i] <= r_cnt[i] + 1'b1;
            end
        end
    end

`ifdef BNN_SCORE_OUT_EN
    logic [CW-1:0] r_score;

    assign score = r_score;

    // Winning count, captured on the same step as the prediction
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          r_score <= '0;
        else if (r_state == L2 && w_last_h) r_score <= r_cnt[w_arg];
    end
`endif

endmodule

// File: tb/tb_bnn_seq_classifier.sv
// tb_bnn_seq_classifier: directed table-driven checks of the BNN classifier against a behavioural model
module tb_bnn_seq_classifier;

    localparam logic [439:0] TW1 = {
        44'h5A3C96E1F02, 44'hB71D4E8A365, 44'h0F9C2B7D4A1, 44'hE63A5D1C8B9, 44'h3C8F07A2D5E,
        44'h9B14E6F3A70, 44'hD2587C0E9B3, 44'h6AE1F3948C5, 44'h17D94BA6E2F, 44'hC4A3082DF76
    };
    localparam logic [279:0] TW2 = {
        40'hA5F0C3961E, 40'h3B7E19D4C2, 40'hE08C5A6F71, 40'h742DB9E0A3,
        40'hC91F36B58D, 40'h1E6A04C7F9, 40'h5D83E2A1B6
    };

    typedef struct {
        logic [43:0] feat;
        int          pred;
        int          sc;
        int          nz;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [43:0] features;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  prediction;
    logic        t_in_ready, t_out_valid;
    logic [2:0]  t_pred;
    logic [3:0]  m_feat;
    logic        m_iv, m_ir, m_ov, m_or;
    logic [0:0]  m_pred;
`ifdef BNN_SCORE_OUT_EN
    logic [5:0]  score, t_score;
    logic [0:0]  m_score;
`endif

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    vec_t tbl [6];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    bnn_seq_classifier #(.W1(TW1), .W2(TW2)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .features   (features),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .prediction (prediction),
        .out_valid  (out_valid),
`ifdef BNN_SCORE_OUT_EN
        .score      (score),
`endif
        .out_ready  (out_ready)
    );

    bnn_seq_classifier #(.W1(TW1), .W2('0)) u_tie (
        .clk        (clk),
        .rst        (rst),
        .features   (features),
        .in_valid   (in_valid),
        .in_ready   (t_in_ready),
        .prediction (t_pred),
        .out_valid  (t_out_valid),
`ifdef BNN_SCORE_OUT_EN
        .score      (t_score),
`endif
        .out_ready  (out_ready)
    );

    bnn_seq_classifier #(.FEAT_CNT(1), .HIDDEN_CNT(1), .CLASS_CNT(2)) u_min (
        .clk        (clk),
        .rst        (rst),
        .features   (m_feat),
        .in_valid   (m_iv),
        .in_ready   (m_ir),
        .prediction (m_pred),
        .out_valid  (m_ov),
`ifdef BNN_SCORE_OUT_EN
        .score      (m_score),
`endif
        .out_ready  (m_or)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Behavioural reference: integer sums, sign threshold, XNOR popcount, first maximum
    function automatic void model(input logic [43:0] ft, output int pred, output int sc, output int nz);
        int          acc, cnt, best;
        logic [39:0] hid;
        nz = 0;
        for (int h = 0; h < 40; h++) begin
            acc = 0;
            for (int f = 0; f < 11; f++)
                acc += TW1[h*11+f] ? int'(ft[f*4 +: 4]) : -int'(ft[f*4 +: 4]);
            hid[h] = acc >= 0;
            nz += hid[h] ? 0 : 1;
        end
        best = -1;
        pred = 0;
        for (int c = 0; c < 7; c++) begin
            cnt = 0;
            for (int h = 0; h < 40; h++) cnt += (TW2[c*40+h] == hid[h]) ? 1 : 0;
            if (cnt > best) begin
                best = cnt;
                pred = c;
            end
        end
        sc = best;
    endfunction

    // Called at a negedge with the DUT idle; returns cycles from accept edge to out_valid
    task automatic run_one(input logic [43:0] ft, output int lat);
        int busy;
        features = ft;
        in_valid = 1'b1;
        chk("accept_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        features = ~ft;
        lat  = 0;
        busy = 0;
        while (!out_valid && lat < 200) begin
            busy += int'(in_ready);
            @(posedge clk);
            #1;
            lat++;
        end
        chk("busy_in_ready", busy, 0);
    endtask

    initial begin
        int lat, p0, bad, na, nd, acc_e, hs_e;
        features  = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        m_feat    = '0;
        m_iv      = 1'b0;
        m_or      = 1'b1;
        tbl[0].feat = 44'h53352264442;
        tbl[1].feat = 44'h00000000000;
        tbl[2].feat = 44'hFFFFFFFFFFF;
        tbl[3].feat = 44'h123456789AB;
        tbl[4].feat = 44'hF0F0F0F0F0F;
        tbl[5].feat = 44'h84210C3EA57;
        for (int i = 0; i < 6; i++) model(tbl[i].feat, tbl[i].pred, tbl[i].sc, tbl[i].nz);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",   int'(in_ready),   1);
        chk("rst_out_valid",  int'(out_valid),  0);
        chk("rst_prediction", int'(prediction), 0);
        chk("rst_min_ready",  int'(m_ir),       1);
        chk("rst_min_valid",  int'(m_ov),       0);

        // Table: first sample lands in the first cycle after reset release
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            run_one(tbl[i].feat, lat);
            chk($sformatf("latency[%0d]", i), lat, 52);
            chk($sformatf("pred[%0d]", i), int'(prediction), tbl[i].pred);
            chk($sformatf("tie_pred[%0d]", i), int'(t_pred), 0);
`ifdef BNN_SCORE_OUT_EN
            chk($sformatf("score[%0d]", i), int'(score), tbl[i].sc);
            chk($sformatf("tie_score[%0d]", i), int'(t_score), tbl[i].nz);
`endif
            @(posedge clk);
            #1;
            chk($sformatf("idle_after_hs[%0d]", i), int'(in_ready), 1);
        end

        // Backpressure: hold DONE for 10 cycles with a competing in_valid
        @(negedge clk);
        out_ready = 1'b0;
        run_one(tbl[5].feat, lat);
        chk("bp_latency", lat, 52);
        p0 = int'(prediction);
        features = 44'h0;
        in_valid = 1'b1;
        bad = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (int'(prediction) != p0 || in_ready || !out_valid) bad++;
        end
        chk("bp_hold", bad, 0);
        chk("bp_pred", int'(prediction), tbl[5].pred);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_ready", int'(in_ready),  1);
        chk("bp_release_valid", int'(out_valid), 0);

        // Back-to-back with in_valid held high
        na   = 0;
        nd   = 0;
        hs_e = 0;
        for (int k = 0; k < 400 && nd < 5; k++) begin
            @(negedge clk);
            in_valid = na < 5;
            features = na < 5 ? tbl[na].feat : '0;
            if (in_ready && in_valid) begin
                acc_e = cyc + 1;
                if (na > 0) chk($sformatf("b2b_gap[%0d]", na), acc_e - hs_e, 1);
                na++;
            end
            if (out_valid && out_ready) begin
                hs_e = cyc + 1;
                chk($sformatf("b2b_pred[%0d]", nd), int'(prediction), tbl[nd].pred);
                nd++;
            end
        end
        chk("b2b_count", nd, 5);
        @(posedge clk);
        #1;

        // Reset in the middle of L1
        @(negedge clk);
        features = tbl[3].feat;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmid_in_ready",   int'(in_ready),   1);
        chk("rstmid_out_valid",  int'(out_valid),  0);
        chk("rstmid_prediction", int'(prediction), 0);
        @(negedge clk);
        rst = 1'b0;
        run_one(tbl[2].feat, lat);
        chk("post_rst_latency", lat, 52);
        chk("post_rst_pred", int'(prediction), tbl[2].pred);
        @(posedge clk);
        #1;

        // Minimal configuration corners: saturated feature (acc=-15) and zero feature (acc=0)
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            m_feat = i == 0 ? 4'hF : 4'h0;
            m_iv   = 1'b1;
            chk($sformatf("min_ready[%0d]", i), int'(m_ir), 1);
            @(posedge clk);
            #1;
            m_iv   = 1'b0;
            m_feat = 4'h5;
            lat    = 0;
            while (!m_ov && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
            end
            chk($sformatf("min_latency[%0d]", i), lat, 3);
            chk($sformatf("min_pred[%0d]", i), int'(m_pred), 0);
`ifdef BNN_SCORE_OUT_EN
            chk($sformatf("min_score[%0d]", i), int'(m_score), i == 0 ? 1 : 0);
`endif
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
